// File: rtl/compare_block_mc.sv
`default_nettype none
// ============================================================================
// Module      : compare_block_mc
// Description : Read-data checker for the memory tester. Compares AMM read
//               words against a fixed byte or per-word PRBS7 pattern, with
//               byte-offset masking of the first/last word, saturating error
//               count and first-error capture. Optional error log FIFO is
//               enabled with `CMP_ERR_LOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================

// Small synchronous FIFO shared by the command, data and log queues.
module compare_block_mc_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign rdata = r_mem[r_rd_ptr[AW-1:0]];

    // Read/write pointers; a push while full is silently dropped.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !full)
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array (no reset needed, guarded by the pointers).
    always_ff @(posedge clk) begin
        if (push && !full)
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module compare_block_mc #(
    parameter int DATA_W  = 128,
    parameter int ADDR_W  = 32,
    parameter int BURST_W = 8,
    parameter int CMD_AW  = 2,
    parameter int DATA_AW = 6
`ifdef CMP_ERR_LOG_EN
    ,
    parameter int LOG_AW  = 3
`endif
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          test_start_i,
    input  logic                          stop_on_err_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [ADDR_W-1:0]             cmd_addr_i,
    input  logic [BURST_W-1:0]            cmd_words_i,
    input  logic [$clog2(DATA_W/8)-1:0]   cmd_start_off_i,
    input  logic [$clog2(DATA_W/8)-1:0]   cmd_end_off_i,
    input  logic [7:0]                    cmd_ptrn_i,
    input  logic                          cmd_rnd_i,
    input  logic                          readdatavalid_i,
    input  logic [DATA_W-1:0]             readdata_i,
    output logic                          cmp_busy_o,
    output logic [31:0]                   err_cnt_o,
    output logic                          data_ovf_o,
    output logic                          first_err_o,
    output logic [ADDR_W-1:0]             first_err_addr_o,
    output logic [$clog2(DATA_W/8)-1:0]   first_err_byte_o,
    output logic [7:0]                    first_err_exp_o,
    output logic [7:0]                    first_err_act_o
`ifdef CMP_ERR_LOG_EN
    ,
    output logic                                        err_log_valid_o,
    input  logic                                        err_log_rd_i,
    output logic [ADDR_W+$clog2(DATA_W/8)+16-1:0]       err_log_q_o,
    output logic                                        err_log_ovf_o
`endif
);
    localparam int DATA_B = DATA_W / 8;
    localparam int OFF_W  = $clog2(DATA_B);
    localparam int CMD_W  = ADDR_W + BURST_W + 2 * OFF_W + 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Reset and test restart clear exactly the same state.
    logic w_clr;
    assign w_clr = !rst_n_i || test_start_i;

    // ---------------- command FIFO ----------------
    logic [CMD_W-1:0]   w_cmd_rdata;
    logic               w_cmd_empty;
    logic               w_cmd_full;
    logic               w_cmd_pop;
    logic [ADDR_W-1:0]  w_hd_addr;
    logic [BURST_W-1:0] w_hd_words;
    logic [OFF_W-1:0]   w_hd_soff;
    logic [OFF_W-1:0]   w_hd_eoff;
    logic [7:0]         w_hd_ptrn;
    logic               w_hd_rnd;

    compare_block_mc_fifo #(.WIDTH(CMD_W), .AW(CMD_AW)) u_cmd_fifo (
        .clk   (clk_i),
        .clr   (w_clr),
        .push  (cmd_valid_i),
        .pop   (w_cmd_pop),
        .wdata ({cmd_addr_i, cmd_words_i, cmd_start_off_i, cmd_end_off_i,
                 cmd_ptrn_i, cmd_rnd_i}),
        .rdata (w_cmd_rdata),
        .empty (w_cmd_empty),
        .full  (w_cmd_full)
    );

    assign {w_hd_addr, w_hd_words, w_hd_soff, w_hd_eoff, w_hd_ptrn, w_hd_rnd} = w_cmd_rdata;
    assign cmd_ready_o = !w_cmd_full;

    // ---------------- read-data FIFO ----------------
    logic [DATA_W-1:0] w_data_rdata;
    logic              w_data_empty;
    logic              w_data_full;
    logic              w_data_pop;

    compare_block_mc_fifo #(.WIDTH(DATA_W), .AW(DATA_AW)) u_data_fifo (
        .clk   (clk_i),
        .clr   (w_clr),
        .push  (readdatavalid_i),
        .pop   (w_data_pop),
        .wdata (readdata_i),
        .rdata (w_data_rdata),
        .empty (w_data_empty),
        .full  (w_data_full)
    );

    // Sticky flag for read words lost because the data FIFO was full.
    always_ff @(posedge clk_i) begin
        if (w_clr)
            data_ovf_o <= 1'b0;
        else if (readdatavalid_i && w_data_full)
            data_ovf_o <= 1'b1;
    end

    // ---------------- active command context ----------------
    logic [ADDR_W-1:0]  r_addr;
    logic [BURST_W-1:0] r_rem;
    logic [OFF_W-1:0]   r_soff;
    logic [OFF_W-1:0]   r_eoff;
    logic [7:0]         r_p;
    logic               r_rnd;
    logic               r_first;

    // ---------------- pipeline stages ----------------
    logic              r_s1_valid;
    logic [DATA_B-1:0] r_s1_mis;
    logic [ADDR_W-1:0] r_s1_addr;
    logic [7:0]        r_s1_p;
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s2_valid;
    logic              r_s2_err;
    logic [ADDR_W-1:0] r_s2_addr;
    logic [OFF_W-1:0]  r_s2_idx;
    logic [7:0]        r_s2_exp;
    logic [7:0]        r_s2_act;

    logic [DATA_B-1:0] w_mis;
    logic [OFF_W-1:0]  w_low_idx;
    logic              w_s1_err;
    logic              w_halt;

    // An erroneous word in S1 halts immediately so no further word is popped.
    assign w_s1_err = r_s1_valid && (|r_s1_mis);
    assign w_halt   = stop_on_err_i && w_s1_err;

    // Next-state and FIFO pop decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_pop   = 1'b0;
        w_data_pop  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_halt)
                    w_state_nxt = ST_HALT;
                else if (!w_cmd_empty)
                    w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_halt) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_cmd_pop   = 1'b1;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_halt) begin
                    w_state_nxt = ST_HALT;
                end else if (!w_data_empty) begin
                    w_data_pop = 1'b1;
                    if (r_rem == '0)
                        w_state_nxt = w_cmd_empty ? ST_IDLE : ST_LOAD;
                end
            end
            ST_HALT: w_state_nxt = ST_HALT;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (w_clr)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Command context: loaded from the FIFO head, then stepped once per word.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_addr  <= '0;
            r_rem   <= '0;
            r_soff  <= '0;
            r_eoff  <= '0;
            r_p     <= '0;
            r_rnd   <= 1'b0;
            r_first <= 1'b0;
        end else if (w_cmd_pop) begin
            r_addr  <= w_hd_addr;
            r_rem   <= w_hd_words;
            r_soff  <= w_hd_soff;
            r_eoff  <= w_hd_eoff;
            r_p     <= w_hd_ptrn;
            r_rnd   <= w_hd_rnd;
            r_first <= 1'b1;
        end else if (w_data_pop) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_first <= 1'b0;
            if (r_rem != '0)
                r_rem <= r_rem - BURST_W'(1);
            if (r_rnd)
                r_p <= {r_p[6:0], r_p[6] ^ r_p[1] ^ r_p[0]};
        end
    end

    // Per-byte mismatch with first/last-word offset masking.
    always_comb begin
        w_mis = '0;
        for (int b = 0; b < DATA_B; b++) begin
            w_mis[b] = (!r_first || (OFF_W'(b) >= r_soff)) &&
                       ((r_rem != '0) || (OFF_W'(b) <= r_eoff)) &&
                       (w_data_rdata[8*b +: 8] != r_p);
        end
    end

    // S1: register mismatch vector and word context.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_s1_valid <= 1'b0;
            r_s1_mis   <= '0;
            r_s1_addr  <= '0;
            r_s1_p     <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_data_pop;
            if (w_data_pop) begin
                r_s1_mis  <= w_mis;
                r_s1_addr <= r_addr;
                r_s1_p    <= r_p;
                r_s1_data <= w_data_rdata;
            end
        end
    end

    // Lowest failing byte index of the S1 word.
    always_comb begin
        w_low_idx = '0;
        for (int b = DATA_B - 1; b >= 0; b--) begin
            if (r_s1_mis[b])
                w_low_idx = OFF_W'(b);
        end
    end

    // S2: register the error record.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            r_s2_valid <= 1'b0;
            r_s2_err   <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_idx   <= '0;
            r_s2_exp   <= '0;
            r_s2_act   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_err   <= w_s1_err;
            r_s2_addr  <= r_s1_addr;
            r_s2_idx   <= w_low_idx;
            r_s2_exp   <= r_s1_p;
            r_s2_act   <= r_s1_data[{w_low_idx, 3'b000} +: 8];
        end
    end

    // Saturating error counter and first-error capture.
    always_ff @(posedge clk_i) begin
        if (w_clr) begin
            err_cnt_o        <= '0;
            first_err_o      <= 1'b0;
            first_err_addr_o <= '0;
            first_err_byte_o <= '0;
            first_err_exp_o  <= '0;
            first_err_act_o  <= '0;
        end else if (r_s2_err) begin
            if (err_cnt_o != '1)
                err_cnt_o <= err_cnt_o + 32'd1;
            if (!first_err_o) begin
                first_err_o      <= 1'b1;
                first_err_addr_o <= r_s2_addr;
                first_err_byte_o <= r_s2_idx;
                first_err_exp_o  <= r_s2_exp;
                first_err_act_o  <= r_s2_act;
            end
        end
    end

    assign cmp_busy_o = (r_state != ST_HALT) &&
                        ((r_state != ST_IDLE) || !w_cmd_empty || r_s1_valid || r_s2_valid);

`ifdef CMP_ERR_LOG_EN
    localparam int LOG_W = ADDR_W + OFF_W + 16;

    logic w_log_empty;
    logic w_log_full;

    compare_block_mc_fifo #(.WIDTH(LOG_W), .AW(LOG_AW)) u_log_fifo (
        .clk   (clk_i),
        .clr   (w_clr),
        .push  (r_s2_err),
        .pop   (err_log_rd_i),
        .wdata ({r_s2_addr, r_s2_idx, r_s2_exp, r_s2_act}),
        .rdata (err_log_q_o),
        .empty (w_log_empty),
        .full  (w_log_full)
    );

    assign err_log_valid_o = !w_log_empty;

    // Sticky flag for error records dropped on a full log.
    always_ff @(posedge clk_i) begin
        if (w_clr)
            err_log_ovf_o <= 1'b0;
        else if (r_s2_err && w_log_full)
            err_log_ovf_o <= 1'b1;
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_compare_block_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_compare_block_mc
// Description : Scoreboard bench for compare_block_mc. Stimulus pushes
//               expected error events; a monitor pops and compares them
//               whenever the error counter advances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_compare_block_mc;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam int DB = 16;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          test_start;
    logic          stop_on_err;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_words;
    logic [OW-1:0] cmd_soff;
    logic [OW-1:0] cmd_eoff;
    logic [7:0]    cmd_ptrn;
    logic          cmd_rnd;
    logic          rdv;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [31:0]   err_cnt;
    logic          data_ovf;
    logic          first_err;
    logic [AW-1:0] fe_addr;
    logic [OW-1:0] fe_byte;
    logic [7:0]    fe_exp;
    logic [7:0]    fe_act;
`ifdef CMP_ERR_LOG_EN
    logic              log_valid;
    logic              log_rd;
    logic [AW+OW+15:0] log_q;
    logic              log_ovf;
`endif

    always #5 clk = ~clk;

    compare_block_mc dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .test_start_i     (test_start),
        .stop_on_err_i    (stop_on_err),
        .cmd_valid_i      (cmd_valid),
        .cmd_ready_o      (cmd_ready),
        .cmd_addr_i       (cmd_addr),
        .cmd_words_i      (cmd_words),
        .cmd_start_off_i  (cmd_soff),
        .cmd_end_off_i    (cmd_eoff),
        .cmd_ptrn_i       (cmd_ptrn),
        .cmd_rnd_i        (cmd_rnd),
        .readdatavalid_i  (rdv),
        .readdata_i       (rdata),
        .cmp_busy_o       (busy),
        .err_cnt_o        (err_cnt),
        .data_ovf_o       (data_ovf),
        .first_err_o      (first_err),
        .first_err_addr_o (fe_addr),
        .first_err_byte_o (fe_byte),
        .first_err_exp_o  (fe_exp),
        .first_err_act_o  (fe_act)
`ifdef CMP_ERR_LOG_EN
        ,
        .err_log_valid_o  (log_valid),
        .err_log_rd_i     (log_rd),
        .err_log_q_o      (log_q),
        .err_log_ovf_o    (log_ovf)
`endif
    );

    typedef struct {
        logic [31:0]   cnt;
        bit            chk_first;
        logic [AW-1:0] addr;
        logic [OW-1:0] idx;
        logic [7:0]    exp_b;
        logic [7:0]    act_b;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] dq[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            exp_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        return {DB{b}};
    endfunction

    function automatic logic [7:0] prbs(input logic [7:0] p);
        return {p[6:0], p[6] ^ p[1] ^ p[0]};
    endfunction

    task automatic expect_err(input logic [AW-1:0] a, input logic [OW-1:0] i,
                              input logic [7:0] e, input logic [7:0] x);
        exp_t it;
        exp_cnt++;
        it.cnt = exp_cnt; it.chk_first = (exp_cnt == 1);
        it.addr = a; it.idx = i; it.exp_b = e; it.act_b = x;
        sb_q.push_back(it);
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [7:0] w, input logic [OW-1:0] so,
                            input logic [OW-1:0] eo, input logic [7:0] p, input logic r);
        int g = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = a; cmd_words = w;
        cmd_soff = so; cmd_eoff = eo; cmd_ptrn = p; cmd_rnd = r;
        while (!cmd_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("cmd_ready_timeout", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_data();
        foreach (dq[i]) begin
            @(negedge clk);
            rdv = 1'b1; rdata = dq[i];
        end
        @(negedge clk);
        rdv = 1'b0;
        dq.delete();
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) check("idle_timeout", busy, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_start();
        check("sb_drained", sb_q.size(), 0);
        @(negedge clk); test_start = 1'b1;
        @(negedge clk); test_start = 1'b0;
        exp_cnt = 0;
    endtask

    // Monitor: every counter advance must match the next expected event.
    initial begin : mon
        logic [31:0] last_cnt;
        exp_t        e;
        last_cnt = 0;
        forever begin
            @(negedge clk);
            if (err_cnt > last_cnt) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_err", err_cnt, last_cnt);
                end else begin
                    e = sb_q.pop_front();
                    check("err_cnt", err_cnt, e.cnt);
                    if (e.chk_first) begin
                        check("first_err", first_err, 1);
                        check("first_err_addr", fe_addr, e.addr);
                        check("first_err_byte", fe_byte, e.idx);
                        check("first_err_exp", fe_exp, e.exp_b);
                        check("first_err_act", fe_act, e.act_b);
                    end
                end
            end
            last_cnt = err_cnt;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [DW-1:0] w;
        logic [7:0]    p;
        rst_n = 0; test_start = 0; stop_on_err = 0; cmd_valid = 0;
        cmd_addr = '0; cmd_words = '0; cmd_soff = '0; cmd_eoff = '0;
        cmd_ptrn = '0; cmd_rnd = 0; rdv = 0; rdata = '0;
`ifdef CMP_ERR_LOG_EN
        log_rd = 0;
`endif
        repeat (3) @(negedge clk);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err", first_err, 0);
        check("rst_busy", busy, 0);
        check("rst_data_ovf", data_ovf, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst_n = 1;

        // T1: fixed 0xA5, matching data queued first; busy falls 3 cycles after last pop.
        for (int k = 0; k < 4; k++) dq.push_back(fill(8'hA5));
        send_data();
        send_cmd(32'h100, 8'd3, 4'd0, 4'd15, 8'hA5, 1'b0);
        check("t1_busy_on", busy, 1);
        repeat (7) @(negedge clk);
        check("t1_busy_tail", busy, 1);
        @(negedge clk);
        check("t1_busy_fall", busy, 0);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_first_err", first_err, 0);

        // T2: PRBS seed 0x01, 8 words, word 3 byte 5 corrupted (word-3 pattern is 0x0D).
        pulse_start();
        expect_err(32'h203, 4'd5, 8'h0D, 8'hF2);
        send_cmd(32'h200, 8'd7, 4'd0, 4'd15, 8'h01, 1'b1);
        p = 8'h01;
        for (int k = 0; k < 8; k++) begin
            w = fill(p);
            if (k == 3) w[5*8 +: 8] = 8'hF2;
            dq.push_back(w);
            p = prbs(p);
        end
        send_data();
        wait_idle();
        check("t2_err_cnt", err_cnt, 1);

        // T3: single word, bytes 4..9 valid; corruption outside is ignored.
        pulse_start();
        w = fill(8'h3C);
        for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'hC3;
        for (int b = 10; b < 16; b++) w[8*b +: 8] = 8'hC3;
        send_cmd(32'h600, 8'd0, 4'd4, 4'd9, 8'h3C, 1'b0);
        dq.push_back(w);
        send_data();
        wait_idle();
        check("t3_masked", err_cnt, 0);
        expect_err(32'h600, 4'd4, 8'h3C, 8'hC3);
        w = fill(8'h3C);
        w[4*8 +: 8] = 8'hC3;
        send_cmd(32'h600, 8'd0, 4'd4, 4'd9, 8'h3C, 1'b0);
        dq.push_back(w);
        send_data();
        wait_idle();
        check("t3_byte4", err_cnt, 1);

        // T3b: two words, first starts at byte 8, last ends at byte 3.
        pulse_start();
        expect_err(32'h501, 4'd3, 8'h3C, 8'h99);
        send_cmd(32'h500, 8'd1, 4'd8, 4'd3, 8'h3C, 1'b0);
        w = fill(8'h3C);
        for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'h00;
        dq.push_back(w);
        w = fill(8'h3C);
        for (int b = 4; b < 16; b++) w[8*b +: 8] = 8'h00;
        w[3*8 +: 8] = 8'h99;
        dq.push_back(w);
        send_data();
        wait_idle();
        check("t3b_err_cnt", err_cnt, 1);

        // T4: stop on error in word 2 of the first of two 16-word commands.
        pulse_start();
        stop_on_err = 1;
        expect_err(32'h302, 4'd7, 8'h55, 8'hAA);
        send_cmd(32'h300, 8'd15, 4'd0, 4'd15, 8'h55, 1'b0);
        send_cmd(32'h400, 8'd15, 4'd0, 4'd15, 8'h55, 1'b0);
        for (int k = 0; k < 32; k++) begin
            w = fill(8'h55);
            if (k == 2)  w[7*8 +: 8] = 8'hAA;
            if (k == 10) w[0 +: 8] = 8'hAA;
            if (k == 16) w[0 +: 8] = 8'hAA;
            dq.push_back(w);
        end
        send_data();
        wait_idle();
        repeat (20) @(negedge clk);
        check("t4_halt_cnt", err_cnt, 1);
        check("t4_halt_busy", busy, 0);
        check("t4_halt_first", first_err, 1);
        pulse_start();
        stop_on_err = 0;
        @(negedge clk);
        check("t4_clr_cnt", err_cnt, 0);
        check("t4_clr_first", first_err, 0);
        check("t4_clr_addr", fe_addr, 0);
        check("t4_clr_busy", busy, 0);
        check("t4_clr_ready", cmd_ready, 1);
        send_cmd(32'h320, 8'd0, 4'd0, 4'd15, 8'h66, 1'b0);
        dq.push_back(fill(8'h66));
        send_data();
        wait_idle();
        check("t4_after_clr", err_cnt, 0);

        // T5: continue on error, 10 failing words.
        pulse_start();
        send_cmd(32'h700, 8'd9, 4'd0, 4'd15, 8'h11, 1'b0);
        for (int k = 0; k < 10; k++) begin
            w = fill(8'h11);
            w[8*k +: 8] = 8'hEE;
            dq.push_back(w);
            expect_err(32'h700 + k, OW'(k), 8'h11, 8'hEE);
        end
        send_data();
        wait_idle();
        check("t5_err_cnt", err_cnt, 10);
`ifdef CMP_ERR_LOG_EN
        check("t5_log_ovf", log_ovf, 1);
        for (int k = 0; k < 8; k++) begin
            check("t5_log_valid", log_valid, 1);
            check("t5_log_rec", log_q, {32'h700 + k, OW'(k), 8'h11, 8'hEE});
            log_rd = 1;
            @(negedge clk);
            log_rd = 0;
        end
        check("t5_log_empty", log_valid, 0);
`endif

        // T6: data FIFO overflow, then reset mid-burst.
        check("sb_drained_t6", sb_q.size(), 0);
        for (int k = 0; k < 65; k++) dq.push_back(fill(8'h77));
        send_data();
        check("t6_data_ovf", data_ovf, 1);
        send_cmd(32'h800, 8'd39, 4'd0, 4'd15, 8'h77, 1'b0);
        repeat (5) @(negedge clk);
        check("t6_busy_mid", busy, 1);
        rst_n = 0;
        @(negedge clk);
        exp_cnt = 0;
        check("t6_rst_cnt", err_cnt, 0);
        check("t6_rst_first", first_err, 0);
        check("t6_rst_addr", fe_addr, 0);
        check("t6_rst_byte", fe_byte, 0);
        check("t6_rst_exp", fe_exp, 0);
        check("t6_rst_act", fe_act, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ovf", data_ovf, 0);
        check("t6_rst_ready", cmd_ready, 1);
`ifdef CMP_ERR_LOG_EN
        check("t6_rst_log_valid", log_valid, 0);
        check("t6_rst_log_ovf", log_ovf, 0);
`endif
        rst_n = 1;

        // T7: after reset, single word failing only in the top byte.
        expect_err(32'h900, 4'd15, 8'h77, 8'h00);
        send_cmd(32'h900, 8'd0, 4'd0, 4'd15, 8'h77, 1'b0);
        w = fill(8'h77);
        w[15*8 +: 8] = 8'h00;
        dq.push_back(w);
        send_data();
        wait_idle();
        check("t7_err_cnt", err_cnt, 1);

        check("sb_drained_end", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
